// File: rtl/ad7608_pkg.sv
// Shared constants and FSM state types for the AD7608 serial-interface emulator.
package ad7608_pkg;
    localparam int NUM_CH      = 8;
    localparam int CH_PER_LANE = 4;

    typedef enum logic {
        IDLE,
        CONV
    } conv_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_SHIFT,
        RD_DONE
    } rd_state_t;
endpackage

// File: rtl/ad7608_emu_lane.sv
// One DOUT lane: a frame-wide shift register, MSB first, zero filled from the right.
module ad7608_emu_lane #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         shift,
    input  logic         clear,
    input  logic [W-1:0] data,
    output logic         msb
);
    logic [W-1:0] sr;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            sr <= '0;
        end else if (load) begin
            sr <= data;
        end else if (shift) begin
            sr <= {sr[W-2:0], 1'b0};
        end
    end

    assign msb = sr[W-1];
endmodule

// File: rtl/ad7608_emulator.sv
// Device-side AD7608 responder: convst/busy conversion timing plus a two-lane serial readout.
module ad7608_emulator
    import ad7608_pkg::*;
#(
    parameter int BITS        = 16,
    parameter int CONV_CYCLES = 16,
    parameter int EDGE_MODE   = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_CH*BITS-1:0] sample_in,
    input  logic                   convst,
    input  logic                   cs,
    input  logic                   sclk_enable,
    output logic                   adc_busy,
    output logic [1:0]             adc_dout,
    output logic                   frame_done,
    output logic                   overrun
);
    localparam int FRAME_BITS = CH_PER_LANE * BITS;
    localparam int BCW        = $clog2(FRAME_BITS) + 1;
    localparam int CCW        = $clog2(CONV_CYCLES);

    conv_state_t conv_state, conv_next;
    rd_state_t   rd_state, rd_next;

    logic [CCW-1:0]         conv_cnt;
    logic [BCW-1:0]         bit_cnt;
    logic [NUM_CH*BITS-1:0] shadow;
    logic [NUM_CH*BITS-1:0] out_latch;
    logic                   last_convst;
    logic                   last_cs;
    logic                   req;
    logic                   capture, finish, ovr_set;
    logic                   lane_load, lane_shift, lane_clear, dout_en, done_pulse;
    logic [FRAME_BITS-1:0]  lane_a_data, lane_b_data;
    logic                   msb_a, msb_b;

    assign req = (EDGE_MODE != 0) ? (convst ^ last_convst) : (convst & ~last_convst);

    // A request on the final busy cycle counts as idle: it restarts rather than overruns.
    always_comb begin
        conv_next = conv_state;
        capture   = 1'b0;
        finish    = 1'b0;
        ovr_set   = 1'b0;
        case (conv_state)
            IDLE: begin
                if (req) begin
                    conv_next = CONV;
                    capture   = 1'b1;
                end
            end
            CONV: begin
                if (conv_cnt == '0) begin
                    finish = 1'b1;
                    if (req) begin
                        capture = 1'b1;
                    end else begin
                        conv_next = IDLE;
                    end
                end else if (req) begin
                    ovr_set = 1'b1;
                end
            end
            default: conv_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            conv_state  <= IDLE;
            conv_cnt    <= '0;
            shadow      <= '0;
            out_latch   <= '0;
            overrun     <= 1'b0;
            last_convst <= 1'b0;
        end else begin
            conv_state  <= conv_next;
            last_convst <= convst;
            if (capture) begin
                shadow   <= sample_in;
                conv_cnt <= CCW'(CONV_CYCLES - 1);
            end else if (conv_state == CONV) begin
                conv_cnt <= conv_cnt - 1'b1;
            end
            if (finish) begin
                out_latch <= shadow;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

    assign adc_busy = (conv_state == CONV);

    // Lane A carries ch0..ch3 and lane B ch4..ch7, lowest channel leaving first.
    always_comb begin
        lane_a_data = '0;
        lane_b_data = '0;
        for (int c = 0; c < CH_PER_LANE; c++) begin
            lane_a_data[(CH_PER_LANE-1-c)*BITS +: BITS] = out_latch[c*BITS +: BITS];
            lane_b_data[(CH_PER_LANE-1-c)*BITS +: BITS] = out_latch[(c+CH_PER_LANE)*BITS +: BITS];
        end
    end

    // cs high always wins over a shift, so an aborted frame never reports done.
    always_comb begin
        rd_next    = rd_state;
        lane_load  = 1'b0;
        lane_shift = 1'b0;
        lane_clear = 1'b0;
        dout_en    = 1'b0;
        done_pulse = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (!cs && last_cs) begin
                    lane_load = 1'b1;
                    rd_next   = RD_SHIFT;
                end
            end
            RD_SHIFT: begin
                if (cs) begin
                    lane_clear = 1'b1;
                    rd_next    = RD_IDLE;
                end else begin
                    dout_en = 1'b1;
                    if (sclk_enable) begin
                        lane_shift = 1'b1;
                        if (bit_cnt == BCW'(FRAME_BITS - 1)) begin
                            done_pulse = 1'b1;
                            rd_next    = RD_DONE;
                        end
                    end
                end
            end
            RD_DONE: begin
                if (cs) begin
                    lane_clear = 1'b1;
                    rd_next    = RD_IDLE;
                end
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_state <= RD_IDLE;
            bit_cnt  <= '0;
            last_cs  <= 1'b1;
        end else begin
            rd_state <= rd_next;
            last_cs  <= cs;
            if (lane_load) begin
                bit_cnt <= '0;
            end else if (lane_shift) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    ad7608_emu_lane #(.W(FRAME_BITS)) u_lane_a (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (lane_load),
        .shift   (lane_shift),
        .clear   (lane_clear),
        .data    (lane_a_data),
        .msb     (msb_a)
    );

    ad7608_emu_lane #(.W(FRAME_BITS)) u_lane_b (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (lane_load),
        .shift   (lane_shift),
        .clear   (lane_clear),
        .data    (lane_b_data),
        .msb     (msb_b)
    );

    assign adc_dout   = dout_en ? {msb_b, msb_a} : 2'b00;
    assign frame_done = done_pulse;
endmodule

// File: tb/tb_ad7608_emulator.sv
// Self-checking bench for ad7608_emulator: conversion timing, serial readout, overrun, abort, gaps, edge mode, reset.
module tb_ad7608_emulator;
    localparam int BITS = 16;
    localparam int CONV = 16;
    localparam int FB   = 4 * BITS;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [8*BITS-1:0] sample_in;
    logic            convst, cs, sclk_enable;
    logic            busy, fd, ovr;
    logic [1:0]      dout;
    logic            busy_e, fd_e, ovr_e;
    logic [1:0]      dout_e;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BITS-1:0] model_latch [8];
    logic [BITS-1:0] exp_q [$];

    always #5 clk = ~clk;

    ad7608_emulator #(.BITS(BITS), .CONV_CYCLES(CONV), .EDGE_MODE(0)) dut (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .convst(convst), .cs(cs),
        .sclk_enable(sclk_enable), .adc_busy(busy), .adc_dout(dout), .frame_done(fd), .overrun(ovr)
    );

    ad7608_emulator #(.BITS(BITS), .CONV_CYCLES(CONV), .EDGE_MODE(1)) dut_e (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .convst(convst), .cs(cs),
        .sclk_enable(sclk_enable), .adc_busy(busy_e), .adc_dout(dout_e), .frame_done(fd_e), .overrun(ovr_e)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- clock/drive helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_model(input logic [8*BITS-1:0] v);
        for (int c = 0; c < 8; c++) model_latch[c] = v[c*BITS +: BITS];
    endtask

    task automatic fill_exp();
        exp_q.delete();
        for (int c = 0; c < 8; c++) exp_q.push_back(model_latch[c]);
    endtask

    function automatic logic [8*BITS-1:0] rand_samples();
        logic [8*BITS-1:0] v;
        for (int c = 0; c < 8; c++) v[c*BITS +: BITS] = BITS'($urandom);
        return v;
    endfunction

    task automatic do_conv(input logic [8*BITS-1:0] v);
        sample_in = v;
        convst = 1'b1;
        step();
        convst = 1'b0;
        repeat (CONV + 4) step();
    endtask

    // Drops cs, then collects nshift enabled bit periods from both lanes.
    task automatic read_frame(input bit gapped, input int nshift,
                              output logic [FB-1:0] a, output logic [FB-1:0] b,
                              output int fd_cnt, output int fd_at, output logic [2:0] post_or);
        int shifts;
        int cyc;
        bit en;
        a = '0; b = '0; fd_cnt = 0; fd_at = -1; post_or = '0;
        cs = 1'b0;
        sclk_enable = 1'b0;
        sample();
        step();
        shifts = 0;
        cyc = 0;
        while (shifts < nshift && cyc < 4 * FB) begin
            en = gapped ? (cyc % 2 == 0) : 1'b1;
            sclk_enable = en;
            sample();
            if (en) begin
                a = {a[FB-2:0], dout[0]};
                b = {b[FB-2:0], dout[1]};
                shifts++;
            end
            if (fd) begin
                fd_cnt++;
                if (fd_at < 0) fd_at = cyc;
            end
            step();
            cyc++;
        end
        if (nshift == FB) begin
            sclk_enable = 1'b1;
            repeat (3) begin
                sample();
                post_or = post_or | {fd, dout};
                if (fd) fd_cnt++;
                step();
            end
        end
        sclk_enable = 1'b0;
    endtask

    task automatic end_read();
        cs = 1'b1;
        sclk_enable = 1'b0;
        step();
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [FB-1:0] a, b;
        int fc, fa;
        logic [2:0] po;
        reset_n = 1'b0; cs = 1'b1; convst = 1'b0; sclk_enable = 1'b0; sample_in = '0;
        repeat (3) step();
        sample();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (dout !== 2'b00) begin n_fail++; $display("FAIL reset_dout got=%b exp=00", dout); end
        n_tests++; if (fd !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b exp=0", fd); end
        n_tests++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", ovr); end
        reset_n = 1'b1;
        step();
        read_frame(1'b0, FB, a, b, fc, fa, po);
        end_read();
        n_tests++; if (a !== '0 || b !== '0) begin n_fail++; $display("FAIL reset_read_zero got a=%h b=%h exp=0", a, b); end
    endtask

    task automatic test_convert_read();
        logic [8*BITS-1:0] v;
        logic [FB-1:0] a, b, ea, eb;
        int fc, fa, first_hi, last_hi;
        logic [2:0] po;
        for (int c = 0; c < 8; c++) v[c*BITS +: BITS] = 16'h1111 * (c + 1);
        repeat (5) step();
        sample_in = v;
        convst = 1'b1;
        first_hi = -1; last_hi = -1;
        for (int i = 0; i <= CONV + 4; i++) begin
            if (i == 3) convst = 1'b0;
            sample();
            if (busy) begin
                if (first_hi < 0) first_hi = i;
                last_hi = i;
            end
            step();
        end
        n_tests++; if (first_hi !== 1) begin n_fail++; $display("FAIL conv_busy_rise got=%0d exp=1", first_hi); end
        n_tests++; if (last_hi !== CONV) begin n_fail++; $display("FAIL conv_busy_fall got=%0d exp=%0d", last_hi, CONV); end
        set_model(v);
        fill_exp();
        read_frame(1'b0, FB, a, b, fc, fa, po);
        end_read();
        ea = {exp_q[0], exp_q[1], exp_q[2], exp_q[3]};
        eb = {exp_q[4], exp_q[5], exp_q[6], exp_q[7]};
        n_tests++; if (a !== ea) begin n_fail++; $display("FAIL conv_lane_a got=%h exp=%h", a, ea); end
        n_tests++; if (b !== eb) begin n_fail++; $display("FAIL conv_lane_b got=%h exp=%h", b, eb); end
        n_tests++; if (fc !== 1) begin n_fail++; $display("FAIL conv_frame_done_count got=%0d exp=1", fc); end
        n_tests++; if (fa !== FB - 1) begin n_fail++; $display("FAIL conv_frame_done_at got=%0d exp=%0d", fa, FB - 1); end
        n_tests++; if (po !== 3'b000) begin n_fail++; $display("FAIL conv_after_done got=%b exp=000", po); end
    endtask

    task automatic test_overrun();
        logic [8*BITS-1:0] v;
        logic [FB-1:0] a, b, ea, eb;
        int fc, fa, first_hi, last_hi;
        logic [2:0] po;
        v = rand_samples();
        sample();
        n_tests++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_initial got=%b exp=0", ovr); end
        step();
        sample_in = v;
        convst = 1'b1;
        first_hi = -1; last_hi = -1;
        for (int i = 0; i <= CONV + 4; i++) begin
            if (i == 1) convst = 1'b0;
            if (i == 5) begin convst = 1'b1; sample_in = '1; end
            if (i == 7) convst = 1'b0;
            sample();
            if (busy) begin
                if (first_hi < 0) first_hi = i;
                last_hi = i;
            end
            step();
        end
        n_tests++; if (first_hi !== 1 || last_hi !== CONV) begin n_fail++; $display("FAIL ovr_busy_window got=%0d..%0d exp=1..%0d", first_hi, last_hi, CONV); end
        sample();
        n_tests++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set got=%b exp=1", ovr); end
        step();
        set_model(v);
        fill_exp();
        read_frame(1'b0, FB, a, b, fc, fa, po);
        end_read();
        ea = {exp_q[0], exp_q[1], exp_q[2], exp_q[3]};
        eb = {exp_q[4], exp_q[5], exp_q[6], exp_q[7]};
        n_tests++; if (a !== ea || b !== eb) begin n_fail++; $display("FAIL ovr_readout got=%h_%h exp=%h_%h", a, b, ea, eb); end
        sample();
        n_tests++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got=%b exp=1", ovr); end
        step();
    endtask

    task automatic test_abort();
        logic [FB-1:0] a, b, ea, eb;
        int fc, fa;
        logic [2:0] po;
        logic [1:0] d_or;
        logic f_or;
        fill_exp();
        ea = {exp_q[0], exp_q[1], exp_q[2], exp_q[3]};
        eb = {exp_q[4], exp_q[5], exp_q[6], exp_q[7]};
        read_frame(1'b0, 20, a, b, fc, fa, po);
        n_tests++; if (a[19:0] !== ea[FB-1 -: 20]) begin n_fail++; $display("FAIL abort_partial got=%h exp=%h", a[19:0], ea[FB-1 -: 20]); end
        n_tests++; if (fc !== 0) begin n_fail++; $display("FAIL abort_partial_done got=%0d exp=0", fc); end
        cs = 1'b1;
        sclk_enable = 1'b1;
        d_or = '0; f_or = 1'b0;
        repeat (3) begin
            sample();
            d_or = d_or | dout;
            f_or = f_or | fd;
            step();
        end
        n_tests++; if (d_or !== 2'b00 || f_or !== 1'b0) begin n_fail++; $display("FAIL abort_cs_high got dout=%b fd=%b exp=00/0", d_or, f_or); end
        read_frame(1'b0, FB, a, b, fc, fa, po);
        end_read();
        n_tests++; if (a[FB-1 -: BITS] !== exp_q[0]) begin n_fail++; $display("FAIL abort_reread_ch0 got=%h exp=%h", a[FB-1 -: BITS], exp_q[0]); end
        n_tests++; if (a !== ea || b !== eb) begin n_fail++; $display("FAIL abort_reread got=%h_%h exp=%h_%h", a, b, ea, eb); end
        n_tests++; if (fc !== 1) begin n_fail++; $display("FAIL abort_reread_done got=%0d exp=1", fc); end
    endtask

    task automatic test_gapped();
        logic [8*BITS-1:0] v;
        logic [FB-1:0] a, b, ea, eb;
        int fc, fa;
        logic [2:0] po;
        v = rand_samples();
        do_conv(v);
        set_model(v);
        fill_exp();
        read_frame(1'b1, FB, a, b, fc, fa, po);
        end_read();
        ea = {exp_q[0], exp_q[1], exp_q[2], exp_q[3]};
        eb = {exp_q[4], exp_q[5], exp_q[6], exp_q[7]};
        n_tests++; if (a !== ea) begin n_fail++; $display("FAIL gap_lane_a got=%h exp=%h", a, ea); end
        n_tests++; if (b !== eb) begin n_fail++; $display("FAIL gap_lane_b got=%h exp=%h", b, eb); end
        n_tests++; if (fc !== 1 || fa !== 2 * FB - 2) begin n_fail++; $display("FAIL gap_frame_done got=%0d@%0d exp=1@%0d", fc, fa, 2 * FB - 2); end
    endtask

    task automatic test_edge_mode();
        logic [8*BITS-1:0] v;
        int first_hi, last_hi, hi0;
        v = rand_samples();
        repeat (CONV + 4) step();
        sample_in = v;
        convst = 1'b1;
        repeat (CONV + 4) step();
        set_model(v);
        convst = 1'b0;
        first_hi = -1; last_hi = -1; hi0 = 0;
        for (int i = 0; i <= CONV + 4; i++) begin
            sample();
            if (busy_e) begin
                if (first_hi < 0) first_hi = i;
                last_hi = i;
            end
            if (busy) hi0++;
            step();
        end
        n_tests++; if (first_hi !== 1 || last_hi !== CONV) begin n_fail++; $display("FAIL edge1_busy got=%0d..%0d exp=1..%0d", first_hi, last_hi, CONV); end
        n_tests++; if (hi0 !== 0) begin n_fail++; $display("FAIL edge0_busy got=%0d exp=0", hi0); end
    endtask

    task automatic test_reset_mid();
        logic [8*BITS-1:0] v;
        logic [FB-1:0] a, b;
        int fc, fa;
        logic [2:0] po;
        sample();
        n_tests++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL rst_ovr_before got=%b exp=1", ovr); end
        step();
        sample_in = rand_samples();
        convst = 1'b1;
        step();
        convst = 1'b0;
        repeat (4) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        sample();
        n_tests++; if (busy !== 1'b0 || dout !== 2'b00 || ovr !== 1'b0) begin n_fail++; $display("FAIL rst_in_conv got busy=%b dout=%b ovr=%b exp=0/00/0", busy, dout, ovr); end
        step();
        v = rand_samples();
        do_conv(v);
        read_frame(1'b0, 10, a, b, fc, fa, po);
        sclk_enable = 1'b1;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        sample();
        n_tests++; if (busy !== 1'b0 || dout !== 2'b00 || ovr !== 1'b0) begin n_fail++; $display("FAIL rst_in_read got busy=%b dout=%b ovr=%b exp=0/00/0", busy, dout, ovr); end
        step();
        end_read();
        for (int c = 0; c < 8; c++) model_latch[c] = '0;
        fill_exp();
        read_frame(1'b0, FB, a, b, fc, fa, po);
        end_read();
        n_tests++; if (a !== {exp_q[0], exp_q[1], exp_q[2], exp_q[3]} || b !== {exp_q[4], exp_q[5], exp_q[6], exp_q[7]}) begin
            n_fail++; $display("FAIL rst_read_zero got=%h_%h exp=0", a, b);
        end
    endtask

    initial begin
        test_reset();
        test_convert_read();
        test_overrun();
        test_abort();
        test_gapped();
        test_edge_mode();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
